// File: rtl/ad9866_pkg.sv
// ad9866_pkg: shared definitions for the AD9866 serial-port sequencer.
//   - frame field positions of the 16-bit serial word {rnw, 2'b00, addr, data}
//   - sequencer state encoding (also visible on the top-level debug port)
//   - register init table, one 13-bit {addr[4:0], data[7:0]} word per entry
//   - make_frame(): builds a serial word from its fields
package ad9866_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RNW_BIT    = 15;
  localparam int ADDR_MSB   = 12;
  localparam int ADDR_LSB   = 8;
  localparam int INIT_MAX   = 32;

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_RST_WAIT  = 3'd1,
    ST_INIT_LOAD = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_GAP       = 3'd4,
    ST_IDLE      = 3'd5
  } state_t;

  // Only the first INIT_LEN entries are replayed; the rest pad the table
  // to the largest supported length.
  localparam logic [12:0] AD9866_INIT [INIT_MAX] = '{
    13'h0084, 13'h0121, 13'h0436, 13'h0500,
    13'h0601, 13'h0700, 13'h0880, 13'h0920,
    13'h0A00, 13'h0B00, 13'h0C41, 13'h0D00,
    13'h0E81, 13'h0F00, 13'h1000, 13'h1100,
    13'h1200, 13'h1300, 13'h1400, 13'h1501,
    13'h0000, 13'h0000, 13'h0000, 13'h0000,
    13'h0000, 13'h0000, 13'h0000, 13'h0000,
    13'h0000, 13'h0000, 13'h0000, 13'h0000
  };

  // Reads carry an all-zero data field; the chip drives SDO instead.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic       rnw,
                                                       input logic [4:0] addr,
                                                       input logic [7:0] data);
    logic [FRAME_BITS-1:0] f;
    f                    = '0;
    f[RNW_BIT]           = rnw;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[7:0]               = rnw ? 8'h00 : data;
    return f;
  endfunction

endpackage

// File: rtl/ad9866_init_rom.sv
// ad9866_init_rom: registered lookup of the init table.
//   clk   in   clock
//   addr  in   5-bit table index
//   data  out  13-bit {addr, data} entry, one cycle after addr
module ad9866_init_rom
  import ad9866_pkg::*;
(
  input  logic        clk,
  input  logic [4:0]  addr,
  output logic [12:0] data
);

  always_ff @(posedge clk) begin
    data <= AD9866_INIT[addr];
  end

endmodule

// File: rtl/ad9866_spi_ctrl.sv
// ad9866_spi_ctrl: AD9866 serial-port configuration sequencer.
// After reset it holds the chip in reset, waits, replays the init table and
// then serves single register reads/writes from the host.
//   IF_clk, IF_rst         clock, synchronous active-high reset
//   req_valid/req_ready    host request handshake
//   req_rnw/addr/wdata     request fields (wdata ignored on reads)
//   rd_valid, rd_data      read result pulse and held read data
//   init_done, busy        status
//   ad9866_*               chip pins (rst_n, sclk, sdio, sdo, sen_n)
//   dbg_state              current sequencer state (state_t encoding)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and drops the
// cycle after a transfer; the host must hold valid and all fields stable
// until the transfer edge. Requests made while busy are stalled, never lost.
module ad9866_spi_ctrl
  import ad9866_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int RST_CYCLES = 1024,
  parameter int INIT_LEN   = 20
) (
  input  logic       IF_clk,
  input  logic       IF_rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [4:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       init_done,
  output logic       busy,
  output logic       ad9866_rst_n,
  output logic       ad9866_sclk,
  output logic       ad9866_sdio,
  input  logic       ad9866_sdo,
  output logic       ad9866_sen_n,
  output logic [2:0] dbg_state
);

  localparam int              RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]   RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0]      IDX_LAST = 5'(INIT_LEN - 1);

  state_t                state;
  logic [RW-1:0]         rst_cnt;
  logic [7:0]            div_cnt;
  logic [3:0]            bit_cnt;
  logic [4:0]            idx;
  logic [FRAME_BITS-1:0] shreg;
  logic                  frame_rnw;
  logic [7:0]            rd_shift;
  logic [4:0]            rom_addr;
  logic [12:0]           rom_data;
  logic                  div_end;
  logic                  accept;

  assign div_end      = (div_cnt == DIV_LAST);
  assign accept       = req_valid && req_ready;
  assign req_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign ad9866_sdio  = shreg[FRAME_BITS-1];
  assign dbg_state    = state;

  // The ROM is addressed with the index the next cycle will hold, so the
  // entry is already registered when INIT_LOAD needs it.
  always_comb begin
    rom_addr = idx;
    if (state == ST_GAP && div_end && !init_done && idx != IDX_LAST)
      rom_addr = idx + 5'd1;
  end

  ad9866_init_rom u_rom (
    .clk  (IF_clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge IF_clk) begin
    if (IF_rst) begin
      state        <= ST_RST_HOLD;
      rst_cnt      <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      idx          <= '0;
      shreg        <= '0;
      frame_rnw    <= 1'b0;
      rd_shift     <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      init_done    <= 1'b0;
      ad9866_rst_n <= 1'b0;
      ad9866_sen_n <= 1'b1;
      ad9866_sclk  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_RST_HOLD: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt      <= '0;
            ad9866_rst_n <= 1'b1;
            state        <= ST_RST_WAIT;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end

        ST_RST_WAIT: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt <= '0;
            idx     <= '0;
            state   <= ST_INIT_LOAD;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end

        // First bit goes out on the same edge that drops sen_n.
        ST_INIT_LOAD: begin
          shreg        <= make_frame(1'b0, rom_data[12:8], rom_data[7:0]);
          frame_rnw    <= 1'b0;
          ad9866_sen_n <= 1'b0;
          ad9866_sclk  <= 1'b0;
          div_cnt      <= '0;
          bit_cnt      <= '0;
          state        <= ST_SHIFT;
        end

        // Each bit: CLK_DIV cycles low then CLK_DIV cycles high. The data
        // shifts when sclk falls, keeping sdio stable around the rise.
        ST_SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (!ad9866_sclk) begin
              ad9866_sclk <= 1'b1;
            end else begin
              // Last high cycle of a data-phase bit: capture SDO.
              if (frame_rnw && bit_cnt[3])
                rd_shift <= {rd_shift[6:0], ad9866_sdo};
              ad9866_sclk <= 1'b0;
              shreg       <= {shreg[FRAME_BITS-2:0], 1'b0};
              if (bit_cnt == 4'd15) begin
                ad9866_sen_n <= 1'b1;
                state        <= ST_GAP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        ST_GAP: begin
          if (div_end) begin
            div_cnt <= '0;
            if (!init_done) begin
              if (idx == IDX_LAST) begin
                init_done <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                idx   <= idx + 5'd1;
                state <= ST_INIT_LOAD;
              end
            end else begin
              if (frame_rnw) begin
                rd_valid <= 1'b1;
                rd_data  <= rd_shift;
              end
              state <= ST_IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        ST_IDLE: begin
          if (accept) begin
            shreg        <= make_frame(req_rnw, req_addr, req_wdata);
            frame_rnw    <= req_rnw;
            ad9866_sen_n <= 1'b0;
            ad9866_sclk  <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            state        <= ST_SHIFT;
          end
        end

        default: state <= ST_RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9866_spi_ctrl.sv
// tb_ad9866_spi_ctrl: self-checking bench for ad9866_spi_ctrl.
// A pin monitor rebuilds each serial frame from sdio at sclk rises and
// compares it with the expected-frame queue; read results are compared
// against a second queue. A small chip model drives sdo during reads.
module tb_ad9866_spi_ctrl;

  localparam int CLK_DIV    = 2;
  localparam int RST_CYCLES = 4;
  localparam int INIT_LEN   = 3;
  localparam int FRAME_CYC  = 32 * CLK_DIV;
  localparam int BOUND      = 2000;

  localparam logic [12:0] INIT_EXP [INIT_LEN] = '{13'h0084, 13'h0121, 13'h0436};

  // clock / reset
  logic       IF_clk = 1'b0;
  logic       IF_rst = 1'b1;
  always #5 IF_clk = ~IF_clk;

  logic       req_valid = 1'b0;
  logic       req_rnw   = 1'b0;
  logic [4:0] req_addr  = '0;
  logic [7:0] req_wdata = '0;
  logic       ad9866_sdo = 1'b0;
  logic       req_ready, rd_valid, init_done, busy;
  logic [7:0] rd_data;
  logic       ad9866_rst_n, ad9866_sclk, ad9866_sdio, ad9866_sen_n;
  logic [2:0] dbg_state;

  ad9866_spi_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .RST_CYCLES (RST_CYCLES),
    .INIT_LEN   (INIT_LEN)
  ) dut (
    .IF_clk       (IF_clk),
    .IF_rst       (IF_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rnw      (req_rnw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .init_done    (init_done),
    .busy         (busy),
    .ad9866_rst_n (ad9866_rst_n),
    .ad9866_sclk  (ad9866_sclk),
    .ad9866_sdio  (ad9866_sdio),
    .ad9866_sdo   (ad9866_sdo),
    .ad9866_sen_n (ad9866_sen_n),
    .dbg_state    (dbg_state)
  );

  // scoreboard state
  logic [15:0] exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic [7:0]  sdo_word = '0;
  int n_checks = 0;
  int n_bad    = 0;
  int rises = 0, low_cycles = 0, hi_cnt = 0, last_gap = 0, frames_done = 0;
  int rd_pulses = 0, sclk_viol = 0, sdio_viol = 0, rdv_viol = 0;
  logic [15:0] cap = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge IF_clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < BOUND) begin
      tick();
      n++;
    end
    check_eq("idle_timeout", (n >= BOUND), 0);
  endtask

  // Push the expected frame (and read data), then hold the request until it transfers.
  task automatic send_req(input logic rnw, input logic [4:0] addr,
                          input logic [7:0] wd, input logic [7:0] rdv);
    int n;
    exp_q.push_back({rnw, 2'b00, addr, (rnw ? 8'h00 : wd)});
    if (rnw) begin
      sdo_word = rdv;
      rd_exp_q.push_back(rdv);
    end
    req_rnw   = rnw;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < BOUND) begin
      tick();
      n++;
    end
    check_eq("accept_timeout", (n >= BOUND), 0);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rst_n"},     ad9866_rst_n, 0);
    check_eq({tag, "_sen_n"},     ad9866_sen_n, 1);
    check_eq({tag, "_sclk"},      ad9866_sclk, 0);
    check_eq({tag, "_sdio"},      ad9866_sdio, 0);
    check_eq({tag, "_ready"},     req_ready, 0);
    check_eq({tag, "_rd_valid"},  rd_valid, 0);
    check_eq({tag, "_rd_data"},   rd_data, 0);
    check_eq({tag, "_init_done"}, init_done, 0);
    check_eq({tag, "_busy"},      busy, 1);
    check_eq({tag, "_state"},     dbg_state, 0);
  endtask

  // Release reset, time the chip-reset phases, then follow the init replay.
  task automatic release_and_init(input logic with_req);
    int lo, hi, n, early;
    for (int i = 0; i < INIT_LEN; i++) exp_q.push_back({3'b000, INIT_EXP[i]});
    if (with_req) exp_q.push_back({req_rnw, 2'b00, req_addr, req_wdata});
    IF_rst = 1'b0;
    lo = 0;
    while (!ad9866_rst_n && lo < BOUND) begin
      lo++;
      tick();
    end
    check_eq("rst_low_cycles", lo, RST_CYCLES);
    hi = 0;
    while (ad9866_sen_n && hi < BOUND) begin
      hi++;
      tick();
    end
    // post-reset wait plus the single ROM-load cycle
    check_eq("rst_wait_cycles", hi, RST_CYCLES + 1);
    n = 0;
    early = 0;
    while (!init_done && n < BOUND) begin
      if (req_ready) early++;
      tick();
      n++;
    end
    check_eq("init_timeout", (n >= BOUND), 0);
    check_eq("ready_before_init", early, 0);
    check_eq("init_frames", frames_done, INIT_LEN);
    check_eq("init_ready", req_ready, 1);
    check_eq("init_busy", busy, 0);
    if (with_req) begin
      tick();
      req_valid = 1'b0;
      check_eq("held_req_accepted", ad9866_sen_n, 0);
      wait_idle();
    end
  endtask

  // pin monitor + SDO chip model
  initial begin
    int k;
    logic prev_sclk, prev_sen_n, prev_sdio, prev_rdv, rst_prev;
    prev_sclk = 1'b0; prev_sen_n = 1'b1; prev_sdio = 1'b0; prev_rdv = 1'b0; rst_prev = 1'b1;
    forever begin
      @(negedge IF_clk);
      if (prev_sen_n && !ad9866_sen_n) begin
        last_gap = hi_cnt;
        hi_cnt   = 0;
      end
      if (ad9866_sen_n) hi_cnt++;
      if (ad9866_sen_n && ad9866_sclk) sclk_viol++;
      if (ad9866_sclk && prev_sclk && ad9866_sdio !== prev_sdio) sdio_viol++;
      if (!ad9866_sen_n) begin
        low_cycles++;
        if (ad9866_sclk && !prev_sclk) begin
          cap = {cap[14:0], ad9866_sdio};
          rises++;
        end
      end
      if (!prev_sen_n && ad9866_sen_n) begin
        if (!rst_prev) begin
          if (exp_q.size() == 0) check_eq("frame_unexpected", cap, 16'hxxxx);
          else check_eq("frame", cap, exp_q.pop_front());
          check_eq("frame_bits", rises, 16);
          check_eq("sen_low_len", low_cycles, FRAME_CYC);
          frames_done++;
        end
        rises = 0;
        low_cycles = 0;
        cap = '0;
      end
      if (rd_valid) begin
        rd_pulses++;
        if (rd_exp_q.size() == 0) check_eq("rd_unexpected", rd_data, 32'hxxxx);
        else check_eq("rd_data", rd_data, rd_exp_q.pop_front());
      end
      if (rd_valid && prev_rdv) rdv_viol++;
      // chip drives read data MSB first across frame bits 8..15
      k = ad9866_sclk ? rises - 1 : rises;
      if (!ad9866_sen_n && k >= 8 && k <= 15) ad9866_sdo = sdo_word[15-k];
      else ad9866_sdo = 1'b0;
      if (IF_rst) begin
        rises = 0;
        low_cycles = 0;
        cap = '0;
        frames_done = 0;
      end
      prev_sclk  = ad9866_sclk;
      prev_sen_n = ad9866_sen_n;
      prev_sdio  = ad9866_sdio;
      prev_rdv   = rd_valid;
      rst_prev   = IF_rst;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic       rnw;
    logic [4:0] a;
    logic [7:0] d, r;

    // power-on reset
    repeat (3) tick();
    check_reset_outputs("reset");
    release_and_init(1'b0);

    // directed write, with acceptance-to-ready timing
    wait_idle();
    exp_q.push_back(16'h0A5C);
    req_rnw = 1'b0; req_addr = 5'h0A; req_wdata = 8'h5C; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check_eq("wr_sen_fall", ad9866_sen_n, 0);
    check_eq("wr_busy", busy, 1);
    n = 1;
    while (!req_ready && n < BOUND) begin
      tick();
      n++;
    end
    check_eq("wr_ready_cycles", n, FRAME_CYC + CLK_DIV + 1);

    // directed read; wdata must not reach the wire
    send_req(1'b1, 5'h13, 8'hFF, 8'hA7);
    wait_idle();
    tick();
    check_eq("rd_pulse_count", rd_pulses, 1);

    // two queued writes back to back
    send_req(1'b0, 5'h05, 8'h3A, 8'h00);
    send_req(1'b0, 5'h1B, 8'hC4, 8'h00);
    wait_idle();
    check_eq("b2b_gap", last_gap, CLK_DIV + 1);
    check_eq("rd_hold", rd_data, 8'hA7);

    // random traffic
    for (int i = 0; i < 6; i++) begin
      rnw = 1'($urandom_range(0, 1));
      a   = 5'($urandom_range(0, 31));
      d   = 8'($urandom_range(0, 255));
      r   = 8'($urandom_range(0, 255));
      send_req(rnw, a, d, r);
      wait_idle();
      tick();
    end

    // reset from IDLE, then abort the first init frame at bit 7
    IF_rst = 1'b1;
    tick();
    check_reset_outputs("rst_idle");
    exp_q.delete();
    IF_rst = 1'b0;
    n = 0;
    while ((ad9866_sen_n || rises != 7) && n < BOUND) begin
      tick();
      n++;
    end
    check_eq("bit7_timeout", (n >= BOUND), 0);
    IF_rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    // request held from reset: stalls through init, then goes out unchanged
    req_rnw = 1'b0; req_addr = 5'h1F; req_wdata = 8'h3C; req_valid = 1'b1;
    release_and_init(1'b1);

    repeat (5) tick();
    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("rd_q_empty", rd_exp_q.size(), 0);
    check_eq("sclk_while_sen_high", sclk_viol, 0);
    check_eq("sdio_change_sclk_high", sdio_viol, 0);
    check_eq("rd_valid_width", rdv_viol, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
